// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the multi-cycle MIPS CPU, sitting between EXE and
//   WB. It unpacks the EXE->MEM bus and drives the data-RAM address,
//   byte-enables and write data. It aligns and extends load data and detects
//   address-alignment exceptions (AdEL for loads, AdES for stores). The
//   result, register-write info, PC and the surviving exception go to WB on
//   MEM_WB_bus.
//
// Configuration macro: MEM_BYTE_ACCESS_EN
//   defined   : LB/LBU/SB byte accesses are supported.
//   undefined : ls_word and lb_sign are ignored and every access is a word
//               access (word alignment check, full enables, full-word load).
//
// Ports
//   clk                 in   1    system clock
//   reset               in   1    asynchronous, active-high reset
//   MEM_valid           in   1    stage holds a valid instruction
//   EXE_MEM_bus_r       in   109  {exc_type,exc_flag,mem_ctrl,alu_res,
//                                   store_data,rf_wen,rf_dest,pc}
//   dm_rdata            in   32   data-RAM read word (synchronous RAM)
//   dm_addr             out  32   data-RAM address
//   dm_wen              out  4    byte write enables
//   dm_wdata            out  32   data-RAM write data
//   MEM_over            out  1    stage finished this cycle
//   MEM_WB_bus          out  73   {exc_flag,exc_type,rf_wen,rf_dest,result,pc}
//   MEM_pc              out  32   PC of the instruction in MEM
//   mem_exception_type  out  2    exception raised here: 00 AdEL, 01 AdES
//   mem_exception_flag  out  1    this stage raised an exception
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_valid,
  input  logic [108:0] EXE_MEM_bus_r,
  input  logic [31:0]  dm_rdata,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  output logic         MEM_over,
  output logic [72:0]  MEM_WB_bus,
  output logic [31:0]  MEM_pc,
  output logic [1:0]   mem_exception_type,
  output logic         mem_exception_flag
);

  logic [1:0]  prev_type;
  logic        prev_flag;
  logic        load;
  logic        store;
  logic        ls_word;
  logic        lb_sign;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic        rf_wen;
  logic [4:0]  rf_dest;
  logic [31:0] pc;

  assign {prev_type, prev_flag, load, store, ls_word, lb_sign,
          alu_res, store_data, rf_wen, rf_dest, pc} = EXE_MEM_bus_r;

  logic        word_access;
  logic [31:0] load_value;
  logic [3:0]  store_wen;
  logic [31:0] store_value;

`ifdef MEM_BYTE_ACCESS_EN
  logic [7:0] load_byte;

  assign word_access = ls_word;

  // Pick the addressed byte out of the RAM word (little-endian lanes).
  always_comb begin
    load_byte = dm_rdata[7:0];
    case (alu_res[1:0])
      2'd0: load_byte = dm_rdata[7:0];
      2'd1: load_byte = dm_rdata[15:8];
      2'd2: load_byte = dm_rdata[23:16];
      2'd3: load_byte = dm_rdata[31:24];
      default: load_byte = dm_rdata[7:0];
    endcase
  end

  assign load_value  = word_access ? dm_rdata
                                   : {{24{lb_sign & load_byte[7]}}, load_byte};
  // Byte stores replicate the byte on every lane; the enable picks the lane.
  assign store_wen   = word_access ? 4'b1111 : (4'b0001 << alu_res[1:0]);
  assign store_value = word_access ? store_data : {4{store_data[7:0]}};
`else
  logic unused_byte_ctrl;

  assign unused_byte_ctrl = ls_word ^ lb_sign;
  assign word_access      = 1'b1;
  assign load_value       = dm_rdata;
  assign store_wen        = 4'b1111;
  assign store_value      = store_data;
`endif

  logic       misaligned;
  logic       own_exc;
  logic [1:0] own_type;
  logic       store_go;
  logic       wait_ram;
  logic       MEM_valid_r;

  // Only real memory accesses can fault, and only word accesses need
  // alignment. An inherited exception suppresses raising a new one.
  assign misaligned = (load | store) & word_access & (alu_res[1:0] != 2'b00);
  assign own_exc    = MEM_valid & ~prev_flag & misaligned;
  assign own_type   = (own_exc & ~load) ? 2'b01 : 2'b00;

  // A store may touch memory only if nothing upstream or here has faulted.
  assign store_go = ~reset & MEM_valid & store & ~own_exc & ~prev_flag;

  // A faulting load never reads RAM, so it does not wait for the read data.
  assign wait_ram = load & ~own_exc;

  // Remembers that the stage was already valid last cycle; this is what
  // gives a load its one extra cycle for the synchronous RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) MEM_valid_r <= 1'b0;
    else       MEM_valid_r <= MEM_valid;
  end

  assign dm_addr            = alu_res;
  assign dm_wen             = store_go ? store_wen : 4'b0000;
  assign dm_wdata           = store_value;
  assign MEM_pc             = pc;
  assign mem_exception_flag = own_exc;
  assign mem_exception_type = own_type;
  assign MEM_over           = ~reset & (wait_ram ? (MEM_valid & MEM_valid_r)
                                                 : MEM_valid);

  // Earlier-stage exceptions take priority over one raised here.
  assign MEM_WB_bus = {prev_flag | own_exc,
                       prev_flag ? prev_type : own_type,
                       rf_wen, rf_dest,
                       load ? load_value : alu_res,
                       pc};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. Directed cases cover the worked
//   examples and reset behaviour; a randomized phase compares every output
//   against a behavioural model computed from the stage's rules.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         MEM_valid;
  logic [108:0] EXE_MEM_bus_r;
  logic [31:0]  dm_rdata;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic         MEM_over;
  logic [72:0]  MEM_WB_bus;
  logic [31:0]  MEM_pc;
  logic [1:0]   mem_exception_type;
  logic         mem_exception_flag;

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .MEM_valid          (MEM_valid),
    .EXE_MEM_bus_r      (EXE_MEM_bus_r),
    .dm_rdata           (dm_rdata),
    .dm_addr            (dm_addr),
    .dm_wen             (dm_wen),
    .dm_wdata           (dm_wdata),
    .MEM_over           (MEM_over),
    .MEM_WB_bus         (MEM_WB_bus),
    .MEM_pc             (MEM_pc),
    .mem_exception_type (mem_exception_type),
    .mem_exception_flag (mem_exception_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] SW  = 4'b0110;
  localparam logic [3:0] LB  = 4'b1001;
  localparam logic [3:0] LBU = 4'b1000;
  localparam logic [3:0] SB  = 4'b0100;
  localparam logic [3:0] NOP = 4'b0000;

  int checks   = 0;
  int failures = 0;

  // Currently applied stimulus, plus the model's memory of last cycle's valid.
  logic        cur_rst, cur_valid, cur_pflag, cur_rfw;
  logic [1:0]  cur_ptype;
  logic [3:0]  cur_ctrl;
  logic [31:0] cur_alu, cur_sd, cur_pc, cur_rdata;
  logic [4:0]  cur_dest;
  logic        model_vr = 1'b0;

  task automatic checkOutput(input string tag, input logic [72:0] actual,
                             input logic [72:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Expected outputs derived from the stage's rules, then compared.
  task automatic compareAll();
    bit is_load, is_store, word, mis, own, any;
    int off;
    logic [1:0]  otype, wtype;
    logic [3:0]  ewen;
    logic [31:0] res, b;
    bit eover, wflag;
    is_load  = cur_ctrl[3];
    is_store = cur_ctrl[2];
`ifdef MEM_BYTE_ACCESS_EN
    word = cur_ctrl[1];
`else
    word = 1'b1;
`endif
    off   = int'(cur_alu % 4);
    mis   = (is_load || is_store) && word && off != 0;
    own   = cur_valid && !cur_pflag && mis;
    otype = (own && !is_load) ? 2'd1 : 2'd0;
    any   = own || cur_pflag;
    ewen  = 4'd0;
    if (!cur_rst && cur_valid && is_store && !any)
      ewen = word ? 4'd15 : 4'(1 << off);
    if (is_load) begin
      if (word) res = cur_rdata;
      else begin
        b = (cur_rdata >> (8 * off)) & 32'hFF;
        res = (cur_ctrl[0] && b >= 128) ? b + 32'hFFFFFF00 : b;
      end
    end else res = cur_alu;
    if (cur_rst) eover = 1'b0;
    else if (is_load && !own) eover = cur_valid && model_vr;
    else eover = cur_valid;
    wflag = cur_pflag ? 1'b1 : own;
    wtype = cur_pflag ? cur_ptype : otype;

    checkOutput("dm_addr", 73'(dm_addr), 73'(cur_alu));
    checkOutput("dm_wen", 73'(dm_wen), 73'(ewen));
    if (ewen != 4'd0)
      checkOutput("dm_wdata", 73'(dm_wdata),
                  73'(word ? cur_sd : {4{cur_sd[7:0]}}));
    checkOutput("MEM_over", 73'(MEM_over), 73'(eover));
    checkOutput("MEM_pc", 73'(MEM_pc), 73'(cur_pc));
    checkOutput("exc_flag", 73'(mem_exception_flag), 73'(own));
    checkOutput("exc_type", 73'(mem_exception_type), 73'(otype));
    checkOutput("MEM_WB_bus", MEM_WB_bus,
                {wflag, wtype, cur_rfw, cur_dest, res, cur_pc});
  endtask

  // Drive one cycle's inputs away from the clock edge and check them.
  task automatic applyStimulus(input logic rst_i, input logic valid_i,
                               input logic [1:0] ptype_i, input logic pflag_i,
                               input logic [3:0] ctrl_i, input logic [31:0] alu_i,
                               input logic [31:0] sd_i, input logic [31:0] rdata_i);
    @(negedge clk);
    cur_rst = rst_i; cur_valid = valid_i; cur_ptype = ptype_i;
    cur_pflag = pflag_i; cur_ctrl = ctrl_i; cur_alu = alu_i; cur_sd = sd_i;
    cur_rdata = rdata_i;
    cur_rfw = 1'($urandom); cur_dest = 5'($urandom); cur_pc = $urandom;
    reset = cur_rst; MEM_valid = cur_valid; dm_rdata = cur_rdata;
    EXE_MEM_bus_r = {cur_ptype, cur_pflag, cur_ctrl, cur_alu, cur_sd,
                     cur_rfw, cur_dest, cur_pc};
    if (cur_rst) model_vr = 1'b0;
    #1;
    compareAll();
  endtask

  task automatic tick();
    @(posedge clk);
    model_vr = cur_rst ? 1'b0 : cur_valid;
  endtask

  task automatic step(input logic rst_i, input logic valid_i,
                      input logic [1:0] ptype_i, input logic pflag_i,
                      input logic [3:0] ctrl_i, input logic [31:0] alu_i,
                      input logic [31:0] sd_i, input logic [31:0] rdata_i);
    applyStimulus(rst_i, valid_i, ptype_i, pflag_i, ctrl_i, alu_i, sd_i, rdata_i);
    tick();
  endtask

  logic [3:0] ctrl_pool [6] = '{LW, SW, LB, LBU, SB, NOP};

  initial begin
    reset = 1'b1; MEM_valid = 1'b0; EXE_MEM_bus_r = '0; dm_rdata = '0;

    // Reset holds off stores and completion regardless of inputs.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, SW, 32'h10, 32'h1234_5678, 32'h0);
    checkOutput("rst_wen", 73'(dm_wen), 73'(4'b0000));
    checkOutput("rst_over", 73'(MEM_over), 73'(1'b0));
    tick();
    step(1'b0, 1'b0, 2'd0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);

    // Aligned LW completes on its second cycle.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h4, 32'h0, 32'hAAAA_AAAA);
    checkOutput("lw_over1", 73'(MEM_over), 73'(1'b0));
    tick();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h4, 32'h0, 32'hAAAA_AAAA);
    checkOutput("lw_over2", 73'(MEM_over), 73'(1'b1));
    checkOutput("lw_result", 73'(MEM_WB_bus[63:32]), 73'(32'hAAAA_AAAA));
    tick();
    step(1'b0, 1'b0, 2'd0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);

    // Misaligned LW faults AdEL and finishes without waiting.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h3, 32'h0, 32'h0);
    checkOutput("lw_mis_bus", 73'(MEM_WB_bus[72:70]), 73'(3'b100));
    checkOutput("lw_mis_over", 73'(MEM_over), 73'(1'b1));
    tick();

    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, SW, 32'h2, 32'hBBBB_BBBB, 32'h0);
    checkOutput("sw_mis_type", 73'(mem_exception_type), 73'(2'b01));
    checkOutput("sw_mis_wen", 73'(dm_wen), 73'(4'b0000));
    tick();

    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, NOP, 32'h0, 32'h0, 32'h0);
    checkOutput("inherit_bus", 73'(MEM_WB_bus[72:70]), 73'(3'b111));
    tick();

    // Inherited fault also blocks an otherwise legal store.
    step(1'b0, 1'b1, 2'b11, 1'b1, SW, 32'h20, 32'h5555_5555, 32'h0);

    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, SW, 32'h10, 32'hCCCC_CCCC, 32'h0);
    checkOutput("sw_wen", 73'(dm_wen), 73'(4'b1111));
    checkOutput("sw_wdata", 73'(dm_wdata), 73'(32'hCCCC_CCCC));
    tick();
    step(1'b0, 1'b1, 2'd0, 1'b0, SW, 32'h11, 32'hDDDD_DDDD, 32'h0);

`ifdef MEM_BYTE_ACCESS_EN
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, LB, 32'h13, 32'h0, 32'h8012_3456);
    checkOutput("lb_result", 73'(MEM_WB_bus[63:32]), 73'(32'hFFFF_FF80));
    tick();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, SB, 32'h12, 32'h0000_00AB, 32'h0);
    checkOutput("sb_wen", 73'(dm_wen), 73'(4'b0100));
    checkOutput("sb_wdata", 73'(dm_wdata), 73'(32'hABAB_ABAB));
    tick();
`endif

    // Reset mid-load aborts it; the next load waits its extra cycle again.
    step(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h40, 32'h0, 32'h1111_2222);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, LW, 32'h40, 32'h0, 32'h1111_2222);
    checkOutput("rst_mid_over", 73'(MEM_over), 73'(1'b0));
    tick();
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h40, 32'h0, 32'h1111_2222);
    checkOutput("relaunch_over", 73'(MEM_over), 73'(1'b0));
    tick();
    step(1'b0, 1'b1, 2'd0, 1'b0, LW, 32'h40, 32'h0, 32'h1111_2222);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0),
           ($urandom_range(0, 4) != 0),
           2'($urandom),
           ($urandom_range(0, 3) == 0),
           ctrl_pool[$urandom_range(0, 5)],
           $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
